// File: rtl/tlc_input_conditioner.sv
// Input conditioning for the traffic light controller: 2-FF sync, debounce, latched pedestrian
// request with stuck-button detection, and qualify/hold hysteresis on the side-street sensor.
module tlc_input_conditioner #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned SIDE_QUAL    = 3,
    parameter int unsigned SIDE_HOLD    = 8,
    parameter int unsigned STUCK_CYCLES = 1000,
    parameter int unsigned CW           = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_btn_raw,
    input  logic side_raw,
    input  logic ped_ack,
    output logic ped,
    output logic side_s,
    output logic ped_fault
);

    localparam logic [1:0] DB_STABLE_LO = 2'd0;
    localparam logic [1:0] DB_CHK_HI    = 2'd1;
    localparam logic [1:0] DB_STABLE_HI = 2'd2;
    localparam logic [1:0] DB_CHK_LO    = 2'd3;

    localparam logic [1:0] SD_IDLE      = 2'd0;
    localparam logic [1:0] SD_QUAL      = 2'd1;
    localparam logic [1:0] SD_PRESENT   = 2'd2;
    localparam logic [1:0] SD_HOLD      = 2'd3;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEB_N   = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] QUAL_N  = CW'(SIDE_QUAL);
    localparam logic [CW-1:0] HOLD_N  = CW'(SIDE_HOLD);
    localparam logic [CW-1:0] STUCK_N = CW'(STUCK_CYCLES);

    // Channel 0 is the pedestrian button, channel 1 the side-street sensor.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_st_q  [2];
    logic [1:0]    db_st_d  [2];
    logic [CW-1:0] db_cnt_q [2];
    logic [CW-1:0] db_cnt_d [2];
    logic [1:0]    db;

    logic          db_ped;
    logic          db_side;
    logic          db_ped_prev_q;
    logic          ped_q;
    logic          ped_d;
    logic          fault_q;
    logic          fault_d;
    logic          stuck_hit;
    logic [CW-1:0] stuck_cnt_q;
    logic [CW-1:0] stuck_cnt_d;

    logic [1:0]    sd_st_q;
    logic [1:0]    sd_st_d;
    logic [CW-1:0] qcnt_q;
    logic [CW-1:0] qcnt_d;

    assign raw     = {side_raw, ped_btn_raw};
    assign db_ped  = db[0];
    assign db_side = db[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_st_d[i]  = db_st_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            case (db_st_q[i])
                DB_STABLE_LO: begin
                    if (sync2_q[i]) begin
                        db_st_d[i]  = DB_CHK_HI;
                        db_cnt_d[i] = ONE;
                    end
                end
                DB_CHK_HI: begin
                    if (!sync2_q[i]) begin
                        db_st_d[i]  = DB_STABLE_LO;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] + ONE >= DEB_N) begin
                        db_st_d[i]  = DB_STABLE_HI;
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + ONE;
                    end
                end
                DB_STABLE_HI: begin
                    if (!sync2_q[i]) begin
                        db_st_d[i]  = DB_CHK_LO;
                        db_cnt_d[i] = ONE;
                    end
                end
                DB_CHK_LO: begin
                    if (sync2_q[i]) begin
                        db_st_d[i]  = DB_STABLE_HI;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] + ONE >= DEB_N) begin
                        db_st_d[i]  = DB_STABLE_LO;
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + ONE;
                    end
                end
                default: begin
                    db_st_d[i]  = DB_STABLE_LO;
                    db_cnt_d[i] = '0;
                end
            endcase
            db[i] = (db_st_q[i] == DB_STABLE_HI) || (db_st_q[i] == DB_CHK_LO);
        end
    end

    always_comb begin
        stuck_cnt_d = '0;
        stuck_hit   = 1'b0;
        if (db_ped) begin
            if (stuck_cnt_q < STUCK_N) begin
                stuck_cnt_d = stuck_cnt_q + ONE;
                stuck_hit   = (stuck_cnt_q + ONE == STUCK_N);
            end else begin
                stuck_cnt_d = stuck_cnt_q;
            end
        end
        fault_d = db_ped & (fault_q | stuck_hit);
        // A fault overrides everything; a fresh press edge beats a simultaneous ack.
        if (fault_d) begin
            ped_d = 1'b0;
        end else if (db_ped && !db_ped_prev_q && !fault_q) begin
            ped_d = 1'b1;
        end else if (ped_ack) begin
            ped_d = 1'b0;
        end else begin
            ped_d = ped_q;
        end
    end

    always_comb begin
        sd_st_d = sd_st_q;
        qcnt_d  = qcnt_q;
        case (sd_st_q)
            SD_IDLE: begin
                if (db_side) begin
                    sd_st_d = SD_QUAL;
                    qcnt_d  = ONE;
                end
            end
            SD_QUAL: begin
                if (!db_side) begin
                    sd_st_d = SD_IDLE;
                    qcnt_d  = '0;
                end else if (qcnt_q + ONE >= QUAL_N) begin
                    sd_st_d = SD_PRESENT;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qcnt_q + ONE;
                end
            end
            SD_PRESENT: begin
                if (!db_side) begin
                    sd_st_d = SD_HOLD;
                    qcnt_d  = ONE;
                end
            end
            SD_HOLD: begin
                if (db_side) begin
                    sd_st_d = SD_PRESENT;
                    qcnt_d  = '0;
                end else if (qcnt_q + ONE >= HOLD_N) begin
                    sd_st_d = SD_IDLE;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qcnt_q + ONE;
                end
            end
            default: begin
                sd_st_d = SD_IDLE;
                qcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                db_st_q[i]  <= DB_STABLE_LO;
                db_cnt_q[i] <= '0;
            end
            db_ped_prev_q <= 1'b0;
            ped_q         <= 1'b0;
            fault_q       <= 1'b0;
            stuck_cnt_q   <= '0;
            sd_st_q       <= SD_IDLE;
            qcnt_q        <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                db_st_q[i]  <= db_st_d[i];
                db_cnt_q[i] <= db_cnt_d[i];
            end
            db_ped_prev_q <= db_ped;
            ped_q         <= ped_d;
            fault_q       <= fault_d;
            stuck_cnt_q   <= stuck_cnt_d;
            sd_st_q       <= sd_st_d;
            qcnt_q        <= qcnt_d;
        end
    end

    assign ped       = ped_q;
    assign ped_fault = fault_q;
    assign side_s    = (sd_st_q == SD_PRESENT) || (sd_st_q == SD_HOLD);

endmodule
